jam_lane_arbiter: RTL and testbench

- Lane-sequencing controller and the initiator side of the jam-hold handshake.
- Normal operation: rotates green among N_LANES lanes round-robin.
- On a jam in the green lane: asserts jam_counter_en to the jam counter, holds green and consumes the counter's check_other_lanes pulse to decide whether to yield.
- Sits between the lane sensor front-end and the signal-head drivers.

---
 rtl/jam_lane_arbiter_if.sv | 24 ++
 rtl/jam_lane_arbiter.sv | 157 +++++++++++++++
 tb/tb_jam_lane_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/jam_lane_arbiter_if.sv
// Lane handshake bundle between the sensor front-end / jam counter (master)
// and the lane arbiter (slave).
interface jam_lane_arbiter_if #(
  parameter int N_LANES = 4,
  parameter int LW      = $clog2(N_LANES)
);
  logic [N_LANES-1:0] lane_req;
  logic [N_LANES-1:0] lane_jam;
  logic               check_other_lanes;
  logic               jam_counter_en;
  logic [N_LANES-1:0] green;
  logic [N_LANES-1:0] yellow;
  logic [LW-1:0]      cur_lane;

  modport master (
    output lane_req, lane_jam, check_other_lanes,
    input  jam_counter_en, green, yellow, cur_lane
  );

  modport slave (
    input  lane_req, lane_jam, check_other_lanes,
    output jam_counter_en, green, yellow, cur_lane
  );
endinterface

// File: rtl/jam_lane_arbiter.sv
// Round-robin lane sequencer with jam-hold: a jammed green lane keeps green
// until the jam counter says to look at the other lanes.
module jam_lane_arbiter #(
  parameter int N_LANES    = 4,
  parameter int LW         = $clog2(N_LANES),
  parameter int NORMAL_CYC = 10,
  parameter int YELLOW_CYC = 3
) (
  input logic               clk,
  input logic               rst_n,
  jam_lane_arbiter_if.slave bus
);

  localparam int GTW = $clog2(NORMAL_CYC);
  localparam int YTW = (YELLOW_CYC > 1) ? $clog2(YELLOW_CYC) : 1;

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW} state_e;

  state_e             state_q, state_d;
  logic [LW-1:0]      cur_lane_q, cur_lane_d;
  logic [N_LANES-1:0] green_q, green_d;
  logic [N_LANES-1:0] yellow_q, yellow_d;
  logic [GTW-1:0]     green_timer_q, green_timer_d;
  logic [YTW-1:0]     yellow_timer_q, yellow_timer_d;

  logic [N_LANES-1:0] demand;
  logic [N_LANES-1:0] other;
  logic               jammed;
  logic [LW-1:0]      sel;
  logic [LW-1:0]      probe;
  logic [LW-1:0]      jam_pick;
  logic [LW-1:0]      req_pick;
  logic               jam_found;
  logic               req_found;

  function automatic logic [N_LANES-1:0] onehot(input logic [LW-1:0] idx);
    logic [N_LANES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign demand = bus.lane_req | bus.lane_jam;
  assign other  = demand & ~onehot(cur_lane_q);
  assign jammed = bus.lane_jam[cur_lane_q];

  // Search starts just past the current lane and ends on it; any jammed lane
  // wins over every plain request.
  always_comb begin
    jam_found = 1'b0;
    req_found = 1'b0;
    jam_pick  = cur_lane_q;
    req_pick  = cur_lane_q;
    probe     = '0;
    for (int i = 1; i <= N_LANES; i++) begin
      probe = LW'((int'(cur_lane_q) + i) % N_LANES);
      if (!jam_found && bus.lane_jam[probe]) begin
        jam_found = 1'b1;
        jam_pick  = probe;
      end
      if (!req_found && bus.lane_req[probe]) begin
        req_found = 1'b1;
        req_pick  = probe;
      end
    end
    sel = jam_found ? jam_pick : req_pick;
  end

  always_comb begin
    state_d        = state_q;
    cur_lane_d     = cur_lane_q;
    green_d        = green_q;
    yellow_d       = yellow_q;
    green_timer_d  = green_timer_q;
    yellow_timer_d = yellow_timer_q;

    unique case (state_q)
      IDLE: begin
        if (demand != '0) begin
          state_d       = GREEN;
          cur_lane_d    = sel;
          green_d       = onehot(sel);
          green_timer_d = '0;
        end
      end

      GREEN: begin
        if (jammed) begin
          if (bus.check_other_lanes && (other != '0)) begin
            state_d        = YELLOW;
            green_d        = '0;
            yellow_d       = onehot(cur_lane_q);
            yellow_timer_d = '0;
          end
        end else if (green_timer_q == GTW'(NORMAL_CYC - 1)) begin
          if ((other == '0) && demand[cur_lane_q]) begin
            green_timer_d = '0;
          end else begin
            state_d        = YELLOW;
            green_d        = '0;
            yellow_d       = onehot(cur_lane_q);
            yellow_timer_d = '0;
          end
        end else begin
          green_timer_d = green_timer_q + 1'b1;
        end
      end

      YELLOW: begin
        if (yellow_timer_q == YTW'(YELLOW_CYC - 1)) begin
          yellow_d = '0;
          // Hand straight to the next green so there is no all-red cycle.
          if (demand != '0) begin
            state_d       = GREEN;
            cur_lane_d    = sel;
            green_d       = onehot(sel);
            green_timer_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          yellow_timer_d = yellow_timer_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        green_d  = '0;
        yellow_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cur_lane_q     <= '0;
      green_q        <= '0;
      yellow_q       <= '0;
      green_timer_q  <= '0;
      yellow_timer_q <= '0;
    end else begin
      state_q        <= state_d;
      cur_lane_q     <= cur_lane_d;
      green_q        <= green_d;
      yellow_q       <= yellow_d;
      green_timer_q  <= green_timer_d;
      yellow_timer_q <= yellow_timer_d;
    end
  end

  assign bus.jam_counter_en = (state_q == GREEN) && jammed;
  assign bus.green          = green_q;
  assign bus.yellow         = yellow_q;
  assign bus.cur_lane       = cur_lane_q;

endmodule

// File: tb/tb_jam_lane_arbiter.sv
// Directed bench for jam_lane_arbiter with 4 lanes, 10-cycle green, 3-cycle
// yellow; the jam counter's pulse is driven by hand.
module tb_jam_lane_arbiter;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   check_cnt;

  jam_lane_arbiter_if #(.N_LANES(4)) bus ();

  jam_lane_arbiter #(
    .N_LANES   (4),
    .NORMAL_CYC(10),
    .YELLOW_CYC(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] req, input logic [3:0] jam,
                                input logic chk);
    bus.lane_req          = req;
    bus.lane_jam          = jam;
    bus.check_other_lanes = chk;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [3:0] g,
                           input logic [3:0] y, input logic [1:0] cur,
                           input logic en);
    check_output({tag, ".green"},    32'(bus.green),          32'(g));
    check_output({tag, ".yellow"},   32'(bus.yellow),         32'(y));
    check_output({tag, ".cur_lane"}, 32'(bus.cur_lane),       32'(cur));
    check_output({tag, ".jam_en"},   32'(bus.jam_counter_en), 32'(en));
  endtask

  initial begin
    pass_cnt  = 0;
    check_cnt = 0;
    rst_n     = 1'b0;
    apply_stimulus(4'b0000, 4'b0000, 1'b0);

    // Reset and quiet idle
    tick(2);
    check_all("reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick(5);
    check_all("idle_quiet", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Single request on lane 2, then released
    apply_stimulus(4'b0100, 4'b0000, 1'b0);
    tick(1);
    check_all("single_green", 4'b0100, 4'b0000, 2'd2, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    tick(9);
    check_all("single_green_end", 4'b0100, 4'b0000, 2'd2, 1'b0);
    tick(1);
    check_all("single_yellow", 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(2);
    check_all("single_yellow_end", 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(1);
    check_all("single_idle", 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Back to cur_lane 0, then lanes 0 and 2 alternate
    rst_n = 1'b0;
    #1;
    check_all("rst_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    apply_stimulus(4'b0101, 4'b0000, 1'b0);
    tick(1);
    check_all("rr_green2", 4'b0100, 4'b0000, 2'd2, 1'b0);
    tick(9);
    check_all("rr_green2_end", 4'b0100, 4'b0000, 2'd2, 1'b0);
    tick(1);
    check_all("rr_yellow2", 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(2);
    check_all("rr_yellow2_end", 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(1);
    check_all("rr_green0", 4'b0001, 4'b0000, 2'd0, 1'b0);
    tick(9);
    check_all("rr_green0_end", 4'b0001, 4'b0000, 2'd0, 1'b0);
    tick(1);
    check_all("rr_yellow0", 4'b0000, 4'b0001, 2'd0, 1'b0);
    tick(3);
    check_all("rr_green2_again", 4'b0100, 4'b0000, 2'd2, 1'b0);

    // Jam on green lane 2 with lane 0 waiting
    apply_stimulus(4'b0001, 4'b0100, 1'b0);
    #1;
    check_all("jam_en_on", 4'b0100, 4'b0000, 2'd2, 1'b1);
    tick(14);
    check_all("jam_hold", 4'b0100, 4'b0000, 2'd2, 1'b1);
    apply_stimulus(4'b0001, 4'b0100, 1'b1);
    tick(1);
    apply_stimulus(4'b0001, 4'b0000, 1'b0);
    #1;
    check_all("jam_yield_yellow", 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(3);
    check_all("jam_yield_green0", 4'b0001, 4'b0000, 2'd0, 1'b0);

    // Move green to lane 2, then jam it with nothing else waiting
    apply_stimulus(4'b0100, 4'b0000, 1'b0);
    tick(10);
    check_all("to2_yellow0", 4'b0000, 4'b0001, 2'd0, 1'b0);
    tick(3);
    check_all("to2_green2", 4'b0100, 4'b0000, 2'd2, 1'b0);
    apply_stimulus(4'b0000, 4'b0100, 1'b0);
    tick(14);
    apply_stimulus(4'b0000, 4'b0100, 1'b1);
    tick(1);
    apply_stimulus(4'b0000, 4'b0100, 1'b0);
    check_all("lone_jam_ignore", 4'b0100, 4'b0000, 2'd2, 1'b1);
    tick(20);
    check_all("lone_jam_hold", 4'b0100, 4'b0000, 2'd2, 1'b1);
    apply_stimulus(4'b1000, 4'b0100, 1'b1);
    tick(1);
    apply_stimulus(4'b1000, 4'b0000, 1'b0);
    #1;
    check_all("lone_jam_yield", 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(3);
    check_all("lone_jam_green3", 4'b1000, 4'b0000, 2'd3, 1'b0);

    // A jam that clears mid-hold must resume, not restart, the green timer
    apply_stimulus(4'b0000, 4'b1000, 1'b0);
    tick(5);
    check_all("freeze_hold", 4'b1000, 4'b0000, 2'd3, 1'b1);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    tick(9);
    check_all("freeze_resume_end", 4'b1000, 4'b0000, 2'd3, 1'b0);
    tick(1);
    check_all("freeze_yellow", 4'b0000, 4'b1000, 2'd3, 1'b0);
    tick(3);
    check_all("freeze_idle", 4'b0000, 4'b0000, 2'd3, 1'b0);

    // Yellow on lane 0: jam on lane 3 beats the nearer request on lane 1
    apply_stimulus(4'b0001, 4'b0000, 1'b0);
    tick(1);
    check_all("prio_green0", 4'b0001, 4'b0000, 2'd0, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    tick(10);
    apply_stimulus(4'b0010, 4'b1000, 1'b0);
    check_all("prio_yellow0", 4'b0000, 4'b0001, 2'd0, 1'b0);
    tick(3);
    check_all("prio_green3", 4'b1000, 4'b0000, 2'd3, 1'b1);

    // Asynchronous reset in the middle of yellow
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    tick(10);
    tick(1);
    check_all("mid_yellow", 4'b0000, 4'b1000, 2'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_all("post_reset", 4'b0000, 4'b0000, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
